wb_slot_sched: RTL and testbench

WB_SLOT_SCHED -- requirements
Module: wb_slot_sched

---
 rtl/wb_slot_sched.sv | 109 ++++++++++
 tb/tb_wb_slot_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slot_sched.sv
// Writeback slot scheduler: reserves the single GPR writeback port for in-flight
// FPU ops and blocks issue on RAW, WAW or writeback-port conflicts.
module wb_slot_sched #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             interlock,
  input  logic             req_valid,
  input  logic [1:0]       req_lat,
  input  logic [4:0]       req_rt,
  input  logic [4:0]       req_rs,
  input  logic [4:0]       req_rs2,
  output logic             grant,
  output logic             stall,
  output logic [1:0]       stall_cause,
  output logic             lat_err,
  output logic             wb_valid,
  output logic [4:0]       wb_rt,
  output logic [31:0]      busy_mask,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [DEPTH-1:0] slot_valid;
  logic [4:0]       slot_rt [DEPTH];
  logic [DEPTH-1:0] slot_valid_nxt;
  logic [4:0]       slot_rt_nxt [DEPTH];

  logic       legal;
  logic [2:0] lat_clk;
  logic       raw_hit;
  logic       waw_hit;
  logic       port_hit;

  always_comb begin
    legal = (req_lat != 2'd3);
    case (req_lat)
      2'd0:    lat_clk = 3'd1;
      2'd1:    lat_clk = 3'd2;
      default: lat_clk = 3'd4;
    endcase
  end

  // slot[L] only exists for L < DEPTH, so the index match covers the range test too
  always_comb begin
    raw_hit   = 1'b0;
    waw_hit   = 1'b0;
    port_hit  = 1'b0;
    busy_mask = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (slot_valid[j]) begin
        busy_mask[slot_rt[j]] = 1'b1;
        if (slot_rt[j] == req_rs || slot_rt[j] == req_rs2) raw_hit = 1'b1;
        if (slot_rt[j] == req_rt) waw_hit = 1'b1;
        if (j == int'(lat_clk)) port_hit = 1'b1;
      end
    end
  end

  always_comb begin
    stall       = rstn & req_valid & legal & (raw_hit | waw_hit | port_hit);
    grant       = rstn & req_valid & legal & ~stall & ~interlock;
    stall_cause = 2'd0;
    if (stall) begin
      if (raw_hit)      stall_cause = 2'd1;
      else if (waw_hit) stall_cause = 2'd2;
      else              stall_cause = 2'd3;
    end
  end

  // shift toward slot[0], then drop the new reservation at L-1
  always_comb begin
    for (int j = 0; j < DEPTH - 1; j++) begin
      slot_valid_nxt[j] = slot_valid[j+1];
      slot_rt_nxt[j]    = slot_rt[j+1];
    end
    slot_valid_nxt[DEPTH-1] = 1'b0;
    slot_rt_nxt[DEPTH-1]    = 5'd0;
    if (grant) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j == int'(lat_clk) - 1) begin
          slot_valid_nxt[j] = 1'b1;
          slot_rt_nxt[j]    = req_rt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_valid <= '0;
      for (int j = 0; j < DEPTH; j++) slot_rt[j] <= 5'd0;
      stall_cnt  <= '0;
      lat_err    <= 1'b0;
    end else begin
      lat_err <= req_valid & ~legal;
      if (!interlock) begin
        slot_valid <= slot_valid_nxt;
        for (int j = 0; j < DEPTH; j++) slot_rt[j] <= slot_rt_nxt[j];
        if (req_valid && stall) stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  assign wb_valid = slot_valid[0];
  assign wb_rt    = slot_rt[0];

endmodule

// File: tb/tb_wb_slot_sched.sv
// Bench for wb_slot_sched: directed scenarios plus randomized traffic checked
// against a model that tracks reservations by absolute writeback cycle.
module tb_wb_slot_sched;

  localparam int DEPTH = 4;
  localparam int CNT_W = 32;

  logic             clk;
  logic             rstn;
  logic             interlock;
  logic             req_valid;
  logic [1:0]       req_lat;
  logic [4:0]       req_rt;
  logic [4:0]       req_rs;
  logic [4:0]       req_rs2;
  logic             grant;
  logic             stall;
  logic [1:0]       stall_cause;
  logic             lat_err;
  logic             wb_valid;
  logic [4:0]       wb_rt;
  logic [31:0]      busy_mask;
  logic [CNT_W-1:0] stall_cnt;

  int checks;
  int failures;

  wb_slot_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .interlock(interlock), .req_valid(req_valid),
    .req_lat(req_lat), .req_rt(req_rt), .req_rs(req_rs), .req_rs2(req_rs2),
    .grant(grant), .stall(stall), .stall_cause(stall_cause), .lat_err(lat_err),
    .wb_valid(wb_valid), .wb_rt(wb_rt), .busy_mask(busy_mask), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: each reservation is {rt, absolute unfrozen cycle of its writeback}
  int          m_rt[$];
  int          m_wb[$];
  int          m_now;
  bit          m_lat_err;
  logic [31:0] m_cnt;

  task automatic model_reset();
    m_rt.delete();
    m_wb.delete();
    m_now     = 0;
    m_lat_err = 1'b0;
    m_cnt     = '0;
  endtask

  task automatic model_eval(output bit e_grant, output bit e_stall, output logic [1:0] e_cause,
                            output bit e_wbv, output logic [4:0] e_wbrt, output logic [31:0] e_busy);
    int L;
    bit legal, raw, waw, conf;
    legal = (req_lat != 2'd3);
    L = (req_lat == 2'd0) ? 1 : (req_lat == 2'd1) ? 2 : 4;
    raw = 0; waw = 0; conf = 0; e_wbv = 0; e_wbrt = '0; e_busy = '0;
    foreach (m_rt[i]) begin
      if (m_wb[i] >= m_now) begin
        if (m_rt[i] == int'(req_rs) || m_rt[i] == int'(req_rs2)) raw = 1;
        if (m_rt[i] == int'(req_rt)) waw = 1;
        if (L <= DEPTH - 1 && m_wb[i] == m_now + L) conf = 1;
        if (m_wb[i] == m_now) begin
          e_wbv  = 1;
          e_wbrt = 5'(m_rt[i]);
        end
        e_busy[m_rt[i]] = 1'b1;
      end
    end
    e_stall = req_valid && legal && (raw || waw || conf);
    e_cause = !e_stall ? 2'd0 : raw ? 2'd1 : waw ? 2'd2 : 2'd3;
    e_grant = req_valid && legal && !e_stall && !interlock;
  endtask

  task automatic model_update(input bit e_grant, input bit e_stall);
    int L;
    L = (req_lat == 2'd0) ? 1 : (req_lat == 2'd1) ? 2 : 4;
    m_lat_err = req_valid && (req_lat == 2'd3);
    if (!interlock) begin
      if (e_grant) begin
        m_rt.push_back(int'(req_rt));
        m_wb.push_back(m_now + L);
      end
      if (req_valid && e_stall) m_cnt = m_cnt + 1;
      m_now++;
      for (int i = m_rt.size() - 1; i >= 0; i--) begin
        if (m_wb[i] < m_now) begin
          m_rt.delete(i);
          m_wb.delete(i);
        end
      end
    end
  endtask

  task automatic set_req(input bit v, input logic [1:0] lat, input logic [4:0] rt,
                         input logic [4:0] rs, input logic [4:0] rs2, input bit il);
    @(negedge clk);
    req_valid = v; req_lat = lat; req_rt = rt; req_rs = rs; req_rs2 = rs2; interlock = il;
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req_valid = 1'b1; req_lat = 2'd1; req_rt = 5'd5; req_rs = 5'd0; req_rs2 = 5'd0; interlock = 1'b0;
    #2;
    checks++; if (grant !== 1'b0) begin failures++; $display("[TB] FAIL reset_grant got=%b want=0", grant); end
    checks++; if (stall !== 1'b0 || stall_cause !== 2'd0) begin failures++; $display("[TB] FAIL reset_stall got=%b/%0d want=0/0", stall, stall_cause); end
    set_req(1'b1, 2'd3, 5'd5, 5'd0, 5'd0, 1'b0);
    checks++; if (wb_valid !== 1'b0 || wb_rt !== 5'd0) begin failures++; $display("[TB] FAIL reset_wb got=%b/%0d want=0/0", wb_valid, wb_rt); end
    checks++; if (lat_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_lat_err got=%b want=0", lat_err); end
    checks++; if (stall_cnt !== '0 || busy_mask !== 32'd0) begin failures++; $display("[TB] FAIL reset_cnt_busy got=%0d/%h want=0/0", stall_cnt, busy_mask); end
  endtask

  task automatic test_fdiv_basic();
    @(negedge clk);
    rstn = 1'b1;
    req_valid = 1'b1; req_lat = 2'd2; req_rt = 5'd5; req_rs = 5'd0; req_rs2 = 5'd0; interlock = 1'b0;
    #1;
    checks++; if (grant !== 1'b1) begin failures++; $display("[TB] FAIL fdiv_grant got=%b want=1", grant); end
    for (int k = 1; k <= 5; k++) begin
      set_req(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0);
      checks++; if (wb_valid !== (k == 4)) begin failures++; $display("[TB] FAIL fdiv_wb_valid cyc=%0d got=%b want=%b", k, wb_valid, k == 4); end
      if (k == 4) begin
        checks++; if (wb_rt !== 5'd5) begin failures++; $display("[TB] FAIL fdiv_wb_rt got=%0d want=5", wb_rt); end
      end
      checks++; if (busy_mask[5] !== (k <= 4)) begin failures++; $display("[TB] FAIL fdiv_busy cyc=%0d got=%b want=%b", k, busy_mask[5], k <= 4); end
    end
  endtask

  task automatic test_port_conflict();
    set_req(1'b1, 2'd2, 5'd3, 5'd0, 5'd0, 1'b0);
    checks++; if (grant !== 1'b1) begin failures++; $display("[TB] FAIL pc_fdiv_grant got=%b want=1", grant); end
    set_req(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    set_req(1'b1, 2'd1, 5'd4, 5'd1, 5'd1, 1'b0);
    checks++; if (stall !== 1'b1 || stall_cause !== 2'd3 || grant !== 1'b0) begin failures++; $display("[TB] FAIL pc_conflict got=%b/%0d/%b want=1/3/0", stall, stall_cause, grant); end
    set_req(1'b1, 2'd1, 5'd4, 5'd1, 5'd1, 1'b0);
    checks++; if (grant !== 1'b1 || stall !== 1'b0) begin failures++; $display("[TB] FAIL pc_retry got=%b/%b want=1/0", grant, stall); end
    set_req(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    checks++; if (wb_valid !== 1'b1 || wb_rt !== 5'd3) begin failures++; $display("[TB] FAIL pc_wb4 got=%b/%0d want=1/3", wb_valid, wb_rt); end
    set_req(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    checks++; if (wb_valid !== 1'b1 || wb_rt !== 5'd4) begin failures++; $display("[TB] FAIL pc_wb5 got=%b/%0d want=1/4", wb_valid, wb_rt); end
    set_req(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("[TB] FAIL pc_wb6 got=%b want=0", wb_valid); end
  endtask

  task automatic test_raw();
    logic [CNT_W-1:0] cnt0;
    set_req(1'b1, 2'd1, 5'd7, 5'd0, 5'd0, 1'b0);
    checks++; if (grant !== 1'b1) begin failures++; $display("[TB] FAIL raw_fmul_grant got=%b want=1", grant); end
    set_req(1'b1, 2'd1, 5'd8, 5'd7, 5'd1, 1'b0);
    cnt0 = stall_cnt;
    checks++; if (stall !== 1'b1 || stall_cause !== 2'd1 || grant !== 1'b0) begin failures++; $display("[TB] FAIL raw_rs got=%b/%0d/%b want=1/1/0", stall, stall_cause, grant); end
    set_req(1'b1, 2'd1, 5'd8, 5'd1, 5'd7, 1'b0);
    checks++; if (stall !== 1'b1 || stall_cause !== 2'd1) begin failures++; $display("[TB] FAIL raw_rs2 got=%b/%0d want=1/1", stall, stall_cause); end
    checks++; if (stall_cnt !== cnt0 + 1) begin failures++; $display("[TB] FAIL raw_cnt1 got=%0d want=%0d", stall_cnt, cnt0 + 1); end
    set_req(1'b1, 2'd1, 5'd8, 5'd1, 5'd7, 1'b0);
    checks++; if (grant !== 1'b1) begin failures++; $display("[TB] FAIL raw_release got=%b want=1", grant); end
    checks++; if (stall_cnt !== cnt0 + 2) begin failures++; $display("[TB] FAIL raw_cnt2 got=%0d want=%0d", stall_cnt, cnt0 + 2); end
    for (int k = 0; k < 3; k++) set_req(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic test_waw();
    set_req(1'b1, 2'd2, 5'd9, 5'd0, 5'd0, 1'b0);
    checks++; if (grant !== 1'b1) begin failures++; $display("[TB] FAIL waw_fdiv_grant got=%b want=1", grant); end
    for (int k = 1; k <= 4; k++) begin
      set_req(1'b1, 2'd0, 5'd9, 5'd1, 5'd2, 1'b0);
      checks++; if (stall !== 1'b1 || stall_cause !== 2'd2 || grant !== 1'b0) begin failures++; $display("[TB] FAIL waw_block cyc=%0d got=%b/%0d/%b want=1/2/0", k, stall, stall_cause, grant); end
    end
    set_req(1'b1, 2'd0, 5'd9, 5'd1, 5'd2, 1'b0);
    checks++; if (grant !== 1'b1 || stall_cause !== 2'd0) begin failures++; $display("[TB] FAIL waw_release got=%b/%0d want=1/0", grant, stall_cause); end
    for (int k = 0; k < 2; k++) set_req(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic test_interlock();
    logic [CNT_W-1:0] cnt0;
    set_req(1'b1, 2'd1, 5'd11, 5'd0, 5'd0, 1'b0);
    checks++; if (grant !== 1'b1) begin failures++; $display("[TB] FAIL il_grant got=%b want=1", grant); end
    cnt0 = stall_cnt + 0;
    for (int k = 1; k <= 3; k++) begin
      set_req(1'b1, 2'd1, 5'd12, 5'd11, 5'd0, 1'b1);
      if (k == 1) cnt0 = stall_cnt;
      checks++; if (grant !== 1'b0 || wb_valid !== 1'b0 || busy_mask[11] !== 1'b1) begin failures++; $display("[TB] FAIL il_frozen cyc=%0d got=%b/%b/%b want=0/0/1", k, grant, wb_valid, busy_mask[11]); end
      checks++; if (stall !== 1'b1 || stall_cause !== 2'd1 || stall_cnt !== cnt0) begin failures++; $display("[TB] FAIL il_stall cyc=%0d got=%b/%0d/%0d want=1/1/%0d", k, stall, stall_cause, stall_cnt, cnt0); end
    end
    set_req(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("[TB] FAIL il_wb_early got=%b want=0", wb_valid); end
    set_req(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    checks++; if (wb_valid !== 1'b1 || wb_rt !== 5'd11) begin failures++; $display("[TB] FAIL il_wb got=%b/%0d want=1/11", wb_valid, wb_rt); end
    set_req(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("[TB] FAIL il_wb_after got=%b want=0", wb_valid); end
  endtask

  task automatic test_illegal_and_reset();
    for (int il = 0; il < 2; il++) begin
      set_req(1'b1, 2'd3, 5'd1, 5'd0, 5'd0, il[0]);
      checks++; if (grant !== 1'b0 || stall !== 1'b0 || lat_err !== 1'b0) begin failures++; $display("[TB] FAIL ill_req il=%0d got=%b/%b/%b want=0/0/0", il, grant, stall, lat_err); end
      set_req(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0);
      checks++; if (lat_err !== 1'b1 || busy_mask !== 32'd0) begin failures++; $display("[TB] FAIL ill_pulse il=%0d got=%b/%h want=1/0", il, lat_err, busy_mask); end
      set_req(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0);
      checks++; if (lat_err !== 1'b0) begin failures++; $display("[TB] FAIL ill_clear il=%0d got=%b want=0", il, lat_err); end
    end
    set_req(1'b1, 2'd1, 5'd2, 5'd0, 5'd0, 1'b0);
    set_req(1'b1, 2'd2, 5'd6, 5'd0, 5'd0, 1'b0);
    checks++; if (grant !== 1'b1) begin failures++; $display("[TB] FAIL rst_fdiv_grant got=%b want=1", grant); end
    set_req(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    checks++; if (wb_valid !== 1'b1 || wb_rt !== 5'd2) begin failures++; $display("[TB] FAIL rst_pre_wb got=%b/%0d want=1/2", wb_valid, wb_rt); end
    rstn = 1'b0;
    #1;
    checks++; if (wb_valid !== 1'b0 || wb_rt !== 5'd0 || busy_mask !== 32'd0) begin failures++; $display("[TB] FAIL rst_async got=%b/%0d/%h want=0/0/0", wb_valid, wb_rt, busy_mask); end
    #1;
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_req(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0);
      checks++; if (wb_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_discard cyc=%0d got=%b/%0d want=0", k, wb_valid, wb_rt); end
    end
  endtask

  task automatic test_random();
    bit          e_grant, e_stall, e_wbv;
    logic [1:0]  e_cause;
    logic [4:0]  e_wbrt;
    logic [31:0] e_busy;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      req_valid = ($urandom_range(0, 3) != 0);
      req_lat   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      req_rt    = 5'($urandom_range(0, 7));
      req_rs    = 5'($urandom_range(0, 15));
      req_rs2   = 5'($urandom_range(0, 15));
      interlock = ($urandom_range(0, 5) == 0);
      #1;
      model_eval(e_grant, e_stall, e_cause, e_wbv, e_wbrt, e_busy);
      checks++; if (grant !== e_grant) begin failures++; $display("[TB] FAIL rnd_grant cyc=%0d got=%b want=%b", c, grant, e_grant); end
      checks++; if (stall !== e_stall) begin failures++; $display("[TB] FAIL rnd_stall cyc=%0d got=%b want=%b", c, stall, e_stall); end
      checks++; if (stall_cause !== e_cause) begin failures++; $display("[TB] FAIL rnd_cause cyc=%0d got=%0d want=%0d", c, stall_cause, e_cause); end
      checks++; if (wb_valid !== e_wbv) begin failures++; $display("[TB] FAIL rnd_wb_valid cyc=%0d got=%b want=%b", c, wb_valid, e_wbv); end
      if (e_wbv) begin
        checks++; if (wb_rt !== e_wbrt) begin failures++; $display("[TB] FAIL rnd_wb_rt cyc=%0d got=%0d want=%0d", c, wb_rt, e_wbrt); end
      end
      checks++; if (busy_mask !== e_busy) begin failures++; $display("[TB] FAIL rnd_busy cyc=%0d got=%h want=%h", c, busy_mask, e_busy); end
      checks++; if (lat_err !== m_lat_err) begin failures++; $display("[TB] FAIL rnd_lat_err cyc=%0d got=%b want=%b", c, lat_err, m_lat_err); end
      checks++; if (stall_cnt !== m_cnt) begin failures++; $display("[TB] FAIL rnd_stall_cnt cyc=%0d got=%0d want=%0d", c, stall_cnt, m_cnt); end
      model_update(e_grant, e_stall);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_fdiv_basic();
    test_port_conflict();
    test_raw();
    test_waw();
    test_interlock();
    test_illegal_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
